// File: rtl/ram_pkg.sv
// Shared sizing helpers and read-pipeline register type for the dual-port data memory.
package ram_pkg;

   // Widest word the read pipeline register can carry; wider instances are rejected.
   localparam int MAX_BYTES = 16;
   localparam int MAX_WIDTH = MAX_BYTES * 8;

   function automatic int idx_width(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

   function automatic int byte_count(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int byte_shift(input int data_width);
      return idx_width(data_width / 8);
   endfunction

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_BYTES      = byte_count(DEF_DATA_WIDTH);
   localparam int DEF_BSH        = byte_shift(DEF_DATA_WIDTH);

   typedef struct packed {
      logic                 valid;
      logic                 err;
      logic [MAX_BYTES-1:0] fwd_mask;
      logic [MAX_WIDTH-1:0] fwd_data;
   } rd_pipe_t;

endpackage

// File: rtl/ram_dp_be_byte_merge.sv
// Per-byte overlay: bytes selected by mask come from overlay, the rest from base.
module byte_merge #(
   parameter int NB = 4
) (
   input  logic [NB*8-1:0] base,
   input  logic [NB*8-1:0] overlay,
   input  logic [NB-1:0]   mask,
   output logic [NB*8-1:0] merged
);

   always_comb begin
      merged = base;
      for (int i = 0; i < NB; i++) begin
         if (mask[i]) merged[8*i +: 8] = overlay[8*i +: 8];
      end
   end

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port byte-enabled data memory with registered read, write-first
// same-word forwarding and out-of-range detection on both ports.
module ram_dp_be
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter int INIT_ZERO   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   w_addr,
   input  logic [DATA_WIDTH/8-1:0] w_be,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   r_addr,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic                    r_valid,
   output logic                    r_err,
   output logic                    w_err
);

   localparam int NB    = byte_count(DATA_WIDTH);
   localparam int BSH   = byte_shift(DATA_WIDTH);
   localparam int IDX_W = idx_width(DEPTH_WORDS);
   localparam int TOP   = BSH + IDX_W;
   localparam logic [DATA_WIDTH-1:0] INIT_WORD =
      (INIT_ZERO != 0) ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bx}};

   generate
      if ((DATA_WIDTH % 8) != 0 || NB > MAX_BYTES || (1 << BSH) != NB)
         $error("ram_dp_be: unsupported DATA_WIDTH %0d", DATA_WIDTH);
      if (DEPTH_WORDS < 2 || (1 << IDX_W) != DEPTH_WORDS)
         $error("ram_dp_be: DEPTH_WORDS %0d must be a power of two >= 2", DEPTH_WORDS);
      if (ADDR_WIDTH < TOP)
         $error("ram_dp_be: ADDR_WIDTH %0d too narrow", ADDR_WIDTH);
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

   logic [IDX_W-1:0]      w_idx, r_idx;
   logic                  w_oor, r_oor, collide;
   logic [DATA_WIDTH-1:0] rd_word_p1;
   rd_pipe_t              pipe_d, pipe_p1;

   assign w_idx = w_addr[BSH +: IDX_W];
   assign r_idx = r_addr[BSH +: IDX_W];

   generate
      if (ADDR_WIDTH > TOP) begin : g_range
         assign w_oor = |w_addr[ADDR_WIDTH-1:TOP];
         assign r_oor = |r_addr[ADDR_WIDTH-1:TOP];
      end else begin : g_full_range
         assign w_oor = 1'b0;
         assign r_oor = 1'b0;
      end
      if (BSH > 0) begin : g_lane_bits
         logic lane_unused;
         assign lane_unused = ^{w_addr[BSH-1:0], r_addr[BSH-1:0]};
      end
      if (NB < MAX_BYTES) begin : g_pad
         logic pad_unused;
         assign pad_unused = ^{pipe_p1.fwd_mask[MAX_BYTES-1:NB],
                               pipe_p1.fwd_data[MAX_WIDTH-1:DATA_WIDTH]};
      end
   endgenerate

   assign collide = we && re && !w_oor && !r_oor && (w_idx == r_idx);

   always_ff @(posedge clk) begin
      if (!rst && we && !w_oor) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   // Stage p1: array read (old contents) plus the forwarding overlay for this edge's write.
   always_comb begin
      pipe_d       = pipe_p1;
      pipe_d.valid = 1'b0;
      pipe_d.err   = 1'b0;
      if (re) begin
         pipe_d.valid    = 1'b1;
         pipe_d.err      = r_oor;
         pipe_d.fwd_mask = '0;
         pipe_d.fwd_data = '0;
         if (collide) pipe_d.fwd_mask[NB-1:0] = w_be;
         pipe_d.fwd_data[DATA_WIDTH-1:0] = w_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_p1    <= '0;
         rd_word_p1 <= '0;
         w_err      <= 1'b0;
      end else begin
         pipe_p1 <= pipe_d;
         w_err   <= we && w_oor;
         if (re) rd_word_p1 <= r_oor ? '0 : mem[r_idx];
      end
   end

   // Output: write-first merge of the registered word with the forwarded bytes.
   byte_merge #(.NB(NB)) u_merge (
      .base    (rd_word_p1),
      .overlay (pipe_p1.fwd_data[DATA_WIDTH-1:0]),
      .mask    (pipe_p1.fwd_mask[NB-1:0]),
      .merged  (r_data)
   );

   // A read captured just before reset must not surface while reset is held.
   assign r_valid = pipe_p1.valid & ~rst;
   assign r_err   = pipe_p1.err;

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: byte enables, forwarding, range errors and reset.
module tb_ram_dp_be;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [31:0] w_addr;
   logic [3:0]  w_be;
   logic [31:0] w_data;
   logic        re;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic        r_valid;
   logic        r_err;
   logic        w_err;

   int n_cmp = 0;
   int n_err = 0;

   ram_dp_be #(
      .DATA_WIDTH  (32),
      .DEPTH_WORDS (256),
      .ADDR_WIDTH  (32),
      .INIT_ZERO   (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .w_addr  (w_addr),
      .w_be    (w_be),
      .w_data  (w_data),
      .re      (re),
      .r_addr  (r_addr),
      .r_data  (r_data),
      .r_valid (r_valid),
      .r_err   (r_err),
      .w_err   (w_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      we = 1'b1; w_addr = a; w_be = be; w_data = d;
      @(negedge clk);
      we = 1'b0; w_be = 4'h0;
   endtask

   task automatic do_read(input logic [31:0] a);
      re = 1'b1; r_addr = a;
      @(negedge clk);
      re = 1'b0;
   endtask

   task automatic do_both(input logic [31:0] wa, input logic [3:0] be, input logic [31:0] d,
                          input logic [31:0] ra);
      we = 1'b1; w_addr = wa; w_be = be; w_data = d;
      re = 1'b1; r_addr = ra;
      @(negedge clk);
      we = 1'b0; w_be = 4'h0; re = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; w_addr = '0; w_be = '0; w_data = '0; re = 1'b0; r_addr = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_r_valid", {31'b0, r_valid}, 32'h0);
      check_eq("rst_r_data",  r_data, 32'h0);
      check_eq("rst_r_err",   {31'b0, r_err}, 32'h0);
      check_eq("rst_w_err",   {31'b0, w_err}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      do_write(32'h10, 4'b1111, 32'hDEADBEEF);
      check_eq("wr10_w_err", {31'b0, w_err}, 32'h0);
      do_read(32'h10);
      check_eq("rd10_valid", {31'b0, r_valid}, 32'h1);
      check_eq("rd10_data",  r_data, 32'hDEADBEEF);
      check_eq("rd10_err",   {31'b0, r_err}, 32'h0);
      @(negedge clk);
      check_eq("idle_valid", {31'b0, r_valid}, 32'h0);
      check_eq("idle_hold",  r_data, 32'hDEADBEEF);

      do_write(32'h20, 4'b1111, 32'h11223344);
      do_write(32'h20, 4'b0010, 32'h0000AA00);
      do_read(32'h20);
      check_eq("be_partial", r_data, 32'h1122AA44);

      do_write(32'h30, 4'b1111, 32'hFFFFFFFF);
      do_both(32'h30, 4'b0101, 32'h00120034, 32'h30);
      check_eq("fwd_valid", {31'b0, r_valid}, 32'h1);
      check_eq("fwd_data",  r_data, 32'hFF12FF34);
      do_read(32'h30);
      check_eq("fwd_reread", r_data, 32'hFF12FF34);

      do_write(32'h44, 4'b1111, 32'h00000005);
      do_both(32'h40, 4'b1111, 32'h12345678, 32'h44);
      check_eq("diff_idx", r_data, 32'h00000005);
      do_read(32'h40);
      check_eq("diff_idx_wr", r_data, 32'h12345678);

      do_write(32'h10, 4'b0000, 32'h00000000);
      check_eq("be0_w_err", {31'b0, w_err}, 32'h0);
      do_read(32'h10);
      check_eq("be0_keep", r_data, 32'hDEADBEEF);

      do_both(32'h400, 4'b1111, 32'hCAFEF00D, 32'h400);
      check_eq("oor_w_err",   {31'b0, w_err}, 32'h1);
      check_eq("oor_r_err",   {31'b0, r_err}, 32'h1);
      check_eq("oor_r_valid", {31'b0, r_valid}, 32'h1);
      check_eq("oor_r_data",  r_data, 32'h0);
      @(negedge clk);
      check_eq("oor_w_err_1cyc", {31'b0, w_err}, 32'h0);
      do_read(32'h0);
      check_eq("oor_alias_data", r_data, 32'h0);
      check_eq("oor_alias_err",  {31'b0, r_err}, 32'h0);
      do_read(32'h80000010);
      check_eq("oor_hi_err",  {31'b0, r_err}, 32'h1);
      check_eq("oor_hi_data", r_data, 32'h0);

      do_read(32'h10);
      check_eq("pre_rst_data", r_data, 32'hDEADBEEF);
      re = 1'b1; r_addr = 32'h10;
      @(negedge clk);
      re = 1'b0;
      rst = 1'b1;
      we = 1'b1; w_addr = 32'h10; w_be = 4'b1111; w_data = 32'h0BAD0BAD;
      #1;
      check_eq("rst_gate_valid", {31'b0, r_valid}, 32'h0);
      @(negedge clk);
      check_eq("rst_edge_valid", {31'b0, r_valid}, 32'h0);
      check_eq("rst_edge_data",  r_data, 32'h0);
      we = 1'b0; w_be = 4'h0;
      rst = 1'b0;
      @(negedge clk);
      do_read(32'h10);
      check_eq("rst_no_write", r_data, 32'hDEADBEEF);
      check_eq("post_rst_valid", {31'b0, r_valid}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
